// File: rtl/nfu_2a_sel_gen_pkg.sv
// NFU-2A select generator shared package.
// Mux geometry and FSM state encoding.
package nfu_2a_sel_gen_pkg;

  localparam int NFU_BIT_WIDTH    = 16;
  localparam int NFU_TN           = 16;
  localparam int NFU_G            = 4;
  localparam int NFU_L1_SEL_WIDTH = 4;
  localparam int NFU_L2_SEL_WIDTH = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } nfu_state_e;

endpackage

// File: rtl/nfu_2a_sel_gen_prio_enc.sv
// Lowest-set-bit encoder for one product group.
// req_i: lane mask; idx_o: lowest set lane (0 if none); any_o: mask non-zero.
module nfu_prio_enc #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = W'(i);
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/nfu_2a_sel_gen.sv
// NFU-2A select-line initiator: drains a pending-product mask into L1/L2 beats.
// Ports: clk/rst_n, i_valid/o_ready/i_mask in, i_stall, sel lines + o_valid/o_last out.
module nfu_2a_sel_gen
  import nfu_2a_sel_gen_pkg::*;
#(
  parameter int BIT_WIDTH    = NFU_BIT_WIDTH,
  parameter int Tn           = NFU_TN,
  parameter int G            = NFU_G,
  parameter int L1_SEL_WIDTH = NFU_L1_SEL_WIDTH,
  parameter int L2_SEL_WIDTH = NFU_L2_SEL_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [G*Tn-1:0]              i_mask,
  input  logic                         i_stall,
  output logic [G*L1_SEL_WIDTH-1:0]    o_l1_sel_lines,
  output logic [G*L2_SEL_WIDTH-1:0]    o_l2_sel_lines,
  output logic                         o_valid,
  output logic                         o_last
);

  if (BIT_WIDTH < 1) begin : g_bw_chk
    $error("BIT_WIDTH must be positive");
  end

  localparam int L1W = L1_SEL_WIDTH;
  localparam int L2W = L2_SEL_WIDTH;

  nfu_state_e             state_q, state_d;
  logic [G*Tn-1:0]        pend_q, pend_d;
  logic [L2W-1:0]         rot_q, rot_d;
  logic [G*L1W-1:0]       l1_q, l1_d;
  logic [G*L2W-1:0]       l2_q, l2_d;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;

  logic [L1W-1:0]         idx [G];
  logic [G-1:0]           any;
  logic [G*L1W-1:0]       l1_beat;
  logic [G*L2W-1:0]       l2_beat;
  logic [G*Tn-1:0]        clr;
  logic [G*Tn-1:0]        rest;
  logic [L2W-1:0]         rot_nx;

  for (genvar g = 0; g < G; g++) begin : g_enc
    nfu_prio_enc #(
      .N(Tn),
      .W(L1W)
    ) u_enc (
      .req_i(pend_q[g*Tn +: Tn]),
      .idx_o(idx[g]),
      .any_o(any[g])
    );
  end

  // Adder input i takes group (i+rot)%G; since rot is never 0 that
  // group differs from i, and L2 code 0 is reserved for the zero input.
  always_comb begin
    l1_beat = '0;
    l2_beat = '0;
    clr     = '0;
    for (int g = 0; g < G; g++) begin
      l1_beat[g*L1W +: L1W] = idx[g];
      if (any[g]) clr[g*Tn + int'(idx[g])] = 1'b1;
    end
    for (int i = 0; i < G; i++) begin
      int s;
      s = (i + int'(rot_q)) % G;
      if (any[s]) begin
        l2_beat[i*L2W +: L2W] = (s < i) ? L2W'(s + 1) : L2W'(s);
      end
    end
    rest = pend_q & ~clr;
  end

  assign rot_nx = (rot_q == L2W'(G - 1)) ? L2W'(1) : rot_q + L2W'(1);

  assign o_ready = (state_q == ST_IDLE) && !i_stall;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    rot_d   = rot_q;
    l1_d    = l1_q;
    l2_d    = l2_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (!i_stall) begin
      unique case (state_q)
        ST_IDLE: begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (i_valid) begin
            pend_d  = i_mask;
            rot_d   = L2W'(1);
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          l1_d    = l1_beat;
          l2_d    = l2_beat;
          valid_d = 1'b1;
          last_d  = (rest == '0);
          pend_d  = rest;
          rot_d   = rot_nx;
          if (rest == '0) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      rot_q   <= L2W'(1);
      l1_q    <= '0;
      l2_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      rot_q   <= rot_d;
      l1_q    <= l1_d;
      l2_q    <= l2_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign o_l1_sel_lines = l1_q;
  assign o_l2_sel_lines = l2_q;
  assign o_valid        = valid_q;
  assign o_last         = last_q;

endmodule

// File: tb/tb_nfu_2a_sel_gen.sv
// Directed bench for nfu_2a_sel_gen.
// Hand-computed beats for default geometry (Tn=16, G=4).
module tb_nfu_2a_sel_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [63:0] i_mask = '0;
  logic        i_stall = 1'b0;
  logic [15:0] o_l1_sel_lines;
  logic [7:0]  o_l2_sel_lines;
  logic        o_valid;
  logic        o_last;

  int total = 0;
  int bad = 0;

  nfu_2a_sel_gen dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_mask(i_mask),
    .i_stall(i_stall),
    .o_l1_sel_lines(o_l1_sel_lines),
    .o_l2_sel_lines(o_l2_sel_lines),
    .o_valid(o_valid),
    .o_last(o_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic v, input logic l,
                      input logic [15:0] e1, input logic [7:0] e2);
    chk({tag, ".valid"}, 64'(o_valid), 64'(v));
    chk({tag, ".last"}, 64'(o_last), 64'(l));
    chk({tag, ".l1"}, 64'(o_l1_sel_lines), 64'(e1));
    chk({tag, ".l2"}, 64'(o_l2_sel_lines), 64'(e2));
  endtask

  task automatic offer(input logic [63:0] m);
    i_mask  = m;
    i_valid = 1'b1;
    chk("offer.ready", 64'(o_ready), 64'd1);
    tick();
    i_valid = 1'b0;
    chk("accept.ready", 64'(o_ready), 64'd0);
    chk("accept.valid", 64'(o_valid), 64'd0);
  endtask

  initial begin
    #1;
    beat("rst", 1'b0, 1'b0, 16'h0000, 8'h00);
    chk("rst.ready", 64'(o_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // single lane 5 in group 0
    offer(64'h0000_0000_0000_0020);
    tick();
    beat("one", 1'b1, 1'b1, 16'h0005, 8'h40);
    tick();
    beat("one.idle", 1'b0, 1'b0, 16'h0005, 8'h40);
    chk("one.ready", 64'(o_ready), 64'd1);

    // lanes 0,1 in every group
    offer(64'h0003_0003_0003_0003);
    tick();
    beat("two.b1", 1'b1, 1'b0, 16'h0000, 8'h79);
    tick();
    beat("two.b2", 1'b1, 1'b1, 16'h1111, 8'h9E);
    tick();

    // all-zero mask
    offer(64'h0);
    tick();
    beat("zero", 1'b1, 1'b1, 16'h0000, 8'h00);
    tick();
    beat("zero.idle", 1'b0, 1'b0, 16'h0000, 8'h00);

    // stall mid-drain
    offer(64'h0000_0010_0000_0085);
    tick();
    beat("stl.b1", 1'b1, 1'b0, 16'h0400, 8'h48);
    i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      beat($sformatf("stl.hold%0d", k), 1'b1, 1'b0, 16'h0400, 8'h48);
    end
    i_stall = 1'b0;
    tick();
    beat("stl.b2", 1'b1, 1'b0, 16'h0002, 8'h10);
    tick();
    beat("stl.b3", 1'b1, 1'b1, 16'h0007, 8'h04);
    tick();
    beat("stl.idle", 1'b0, 1'b0, 16'h0007, 8'h04);

    // reset during beat 2 of a 4-beat mask
    offer(64'h0000_0000_000F_0000);
    tick();
    beat("rr.b1", 1'b1, 1'b0, 16'h0000, 8'h01);
    tick();
    beat("rr.b2", 1'b1, 1'b0, 16'h0010, 8'h80);
    rst_n = 1'b0;
    #1;
    beat("rr.rst", 1'b0, 1'b0, 16'h0000, 8'h00);
    chk("rr.ready", 64'(o_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rr.quiet%0d", k), 64'(o_valid), 64'd0);
    end

    // back-to-back masks, i_valid held high
    i_mask  = 64'h0000_0000_0000_0001;
    i_valid = 1'b1;
    tick();
    i_mask = 64'h0003_0000_0000_0000;
    chk("b2b.busy", 64'(o_ready), 64'd0);
    tick();
    beat("b2b.a", 1'b1, 1'b1, 16'h0000, 8'h40);
    chk("b2b.ready", 64'(o_ready), 64'd1);
    tick();
    i_valid = 1'b0;
    chk("b2b.acc", 64'(o_ready), 64'd0);
    chk("b2b.gap", 64'(o_valid), 64'd0);
    tick();
    beat("b2b.b1", 1'b1, 1'b0, 16'h0000, 8'h30);
    tick();
    beat("b2b.b2", 1'b1, 1'b1, 16'h1000, 8'h0C);
    tick();
    beat("b2b.idle", 1'b0, 1'b0, 16'h1000, 8'h0C);
    chk("b2b.end", 64'(o_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
